led_toggle_bank: RTL and testbench
==================================

# led_toggle_bank

Multi-channel clocked toggle generator driving indicator LEDs: each channel divides `clk` by a programmable ratio, toggles an internal state bit and presents it either true or through the NOR-as-NOT inverting path. It generalises the single-clock NOR-inverter LED demo to CHANNELS independent outputs with runtime divide ratios, per-channel polarity and a handshaked configuration port. It sits beside the multiplier datapath as the board-level activity/status indicator.

## Interface
- CHANNELS, 4: number of independent LED channels (1..16)
- DIV_W, 8: width of each channel's divide-ratio field
- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  global count enable; 0 freezes all counters and states
- cfg_valid  in  1  configuration offer
- cfg_ready  out  1  configuration accept; transfer on `cfg_valid && cfg_ready` at a rising edge
- cfg_div  in  CHANNELS*DIV_W  divide ratio per channel, channel i in bits [i*DIV_W +: DIV_W]
- cfg_inv  in  CHANNELS  per-channel inversion select (1 = NOR-as-NOT path)
- led  out  CHANNELS  LED drive
- tick  out  CHANNELS  one-cycle pulse on the edge where channel i toggles

## Operation
- Per channel: active `div[i]`, active `inv[i]`, counter `cnt[i]` (DIV_W bits), state bit `st[i]`.
- `en=1`, `div[i]≥1`: if `cnt[i]==div[i]-1` then `cnt[i]←0`, `st[i]←~st[i]`, `tick[i]=1`; else `cnt[i]←cnt[i]+1`. Output period = 2·div clocks.
- `div[i]=0`: channel stopped, `cnt` and `st` hold, no tick.
- `div[i]=1`: toggle every cycle (clk/2).
- `led[i] = inv[i] ? ~(st[i] | st[i]) : st[i]`, with the inversion built as a 2-input NOR whose inputs are tied together.
- Config accept captures cfg_div/cfg_inv into pending registers and sets a pending flag per channel; cfg_ready drops to 0 on the following cycle.
- Deferred apply (default): pending values for channel i load into active on its next wrap edge (same edge as the toggle). They load on the next edge regardless of counter when that channel is stopped (`div[i]=0`) or `en=0`. Loading a new div never truncates a running period.
- cfg_ready returns to 1 the cycle after the last pending channel applies.
- `en=0`: counters and states frozen, tick=0, led static.

## Timing
- Reset values: cnt=0, st=0, div=0, inv=0, pending flags=0, led=0, tick=0, cfg_ready=1.
- Reset mid-operation discards pending config and in-flight counts within one edge.
- Outputs are registered state plus the NOR inverter; led changes on the toggle edge, with zero added latency.
- cfg_ready stays low for at most max(old div[i]) + 1 cycles while `en=1`, and for 1 cycle while `en=0`.
- A cfg_valid held high while cfg_ready=0 is not accepted. Data must stay stable until accepted.
- cfg_div field = 0 stops the channel after apply, with st held at its current value.

## Configuration
- `LED_PHASE_ALIGN_EN` defined: on the accept edge all channels load div/inv immediately, `cnt←0`, `st←0`, and no tick fires on that edge. cfg_ready stays 1 permanently, and all channels restart phase-aligned.
- Undefined: deferred per-channel apply as in Operation.

## Structure
- Package `led_toggle_pkg`: CHANNELS/DIV_W defaults, the `div_t` typedef, and the `DIV_STOP = 0` constant.
- Sub-module `led_toggle_ch` holds one channel's counter, state, pending register and the NOR inverter, and is instantiated CHANNELS times. The top holds the handshake and the ready aggregation.

## Test plan
- Reset, then config div={1,2,3,0}, inv=0, en=1: led0 toggles every cycle, led1 every 2 cycles, led2 every 3 cycles, led3 holds 0; tick is one-cycle on each toggle.
- Config ch0 div=4 with inv=1, then inv=0: led0 is the exact complement of st0 while inv=1, and equals st0 after the second config applies.
- Running ch1 div=200, at cnt=50 offer div=3: the current 200-cycle half-period completes, then the 3-cycle period starts. cfg_ready is low ≈150 cycles, then goes high.
- en=0 mid-count for 10 cycles: cnt/st/led are frozen with no tick, and counting resumes from the same cnt when en=1.
- Assert rst while a config is pending: next cycle all outputs are at reset values, cfg_ready=1, and the pending config is discarded.
- With `LED_PHASE_ALIGN_EN`: config div={2,4,2,4} mid-run puts all channels at st=0 on the accept edge, and ch0 and ch2 stay identical thereafter.

Source files
------------

// File: rtl/led_toggle_pkg.sv
// Shared constants and types for the LED toggle bank.
// Optional build macro LED_PHASE_ALIGN_EN selects immediate, phase-aligned config apply.
package led_toggle_pkg;

    localparam int CHANNELS_DEF = 4;
    localparam int DIV_W_DEF    = 8;

    typedef logic [DIV_W_DEF-1:0] div_t;

    localparam int DIV_STOP = 0;

    typedef enum logic {
        CFG_IDLE = 1'b0,
        CFG_BUSY = 1'b1
    } cfg_state_t;

endpackage

// File: rtl/led_toggle_bank_if.sv
// Configuration handshake port of the LED toggle bank.
// Behaviour under LED_PHASE_ALIGN_EN differs only inside the bank, not on this port.
interface led_toggle_bank_if #(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 8
);

    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [CHANNELS*DIV_W-1:0] cfg_div;
    logic [CHANNELS-1:0]       cfg_inv;

    modport master (
        output cfg_valid,
        output cfg_div,
        output cfg_inv,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        input  cfg_inv,
        output cfg_ready
    );

endinterface

// File: rtl/led_toggle_ch.sv
// One LED channel: divide counter, toggle state, pending config and NOR inverter.
// LED_PHASE_ALIGN_EN: config loads on the accept edge and restarts the channel phase.
module led_toggle_ch
    import led_toggle_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] load_div,
    input  logic             load_inv,
    output logic             led,
    output logic             tick,
    output logic             pend,
    output logic             apply
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic             inv_q;
    logic             st_q;
    logic             tick_q;
    logic             running;
    logic             wrap;
    logic             nor_out;

    assign running = en && (div_q != DIV_W'(DIV_STOP));
    // >= rather than == so a counter left beyond a smaller new ratio still wraps
    assign wrap    = running && (cnt_q >= (div_q - DIV_W'(1)));

    // Inverting path is a 2-input NOR with both inputs on the state bit
    assign nor_out = ~(st_q | st_q);
    assign led     = inv_q ? nor_out : st_q;
    assign tick    = tick_q;

`ifdef LED_PHASE_ALIGN_EN
    assign pend  = 1'b0;
    assign apply = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            inv_q  <= 1'b0;
            cnt_q  <= '0;
            st_q   <= 1'b0;
            tick_q <= 1'b0;
        end else if (load) begin
            div_q  <= load_div;
            inv_q  <= load_inv;
            cnt_q  <= '0;
            st_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= wrap;
            if (wrap) begin
                cnt_q <= '0;
                st_q  <= ~st_q;
            end else if (running) begin
                cnt_q <= cnt_q + DIV_W'(1);
            end
        end
    end
`else
    logic [DIV_W-1:0] pdiv_q;
    logic             pinv_q;
    logic             pend_q;

    // A stopped or frozen channel has no wrap to wait for, so it takes config at once
    assign apply = pend_q && (wrap || !running);
    assign pend  = pend_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            inv_q  <= 1'b0;
            cnt_q  <= '0;
            st_q   <= 1'b0;
            tick_q <= 1'b0;
            pdiv_q <= '0;
            pinv_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            tick_q <= wrap;
            if (wrap) begin
                cnt_q <= '0;
                st_q  <= ~st_q;
            end else if (running) begin
                cnt_q <= cnt_q + DIV_W'(1);
            end
            if (load) begin
                pdiv_q <= load_div;
                pinv_q <= load_inv;
                pend_q <= 1'b1;
            end else if (apply) begin
                div_q  <= pdiv_q;
                inv_q  <= pinv_q;
                pend_q <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: rtl/led_toggle_bank.sv
// Multi-channel LED toggle generator with handshaked divide/polarity configuration.
// LED_PHASE_ALIGN_EN: immediate phase-aligned apply, cfg_ready held high.
//
// state    | meaning
// CFG_IDLE | no channel has pending config, cfg_ready = 1
// CFG_BUSY | at least one channel still waits to apply, cfg_ready = 0
module led_toggle_bank
    import led_toggle_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int DIV_W    = DIV_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    led_toggle_bank_if.slave    cfg,
    output logic [CHANNELS-1:0] led,
    output logic [CHANNELS-1:0] tick
);

    logic                accept;
    logic [CHANNELS-1:0] pend;
    logic [CHANNELS-1:0] apply;

    assign accept = cfg.cfg_valid && cfg.cfg_ready;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        led_toggle_ch #(.DIV_W(DIV_W)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .load     (accept),
            .load_div (cfg.cfg_div[i*DIV_W +: DIV_W]),
            .load_inv (cfg.cfg_inv[i]),
            .led      (led[i]),
            .tick     (tick[i]),
            .pend     (pend[i]),
            .apply    (apply[i])
        );
    end

`ifdef LED_PHASE_ALIGN_EN
    logic unused_handshake;

    assign unused_handshake = ^{pend, apply};
    assign cfg.cfg_ready    = 1'b1;
`else
    cfg_state_t state_q;
    cfg_state_t state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CFG_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave BUSY on the edge where the last pending channel applies
    always_comb begin
        state_d = state_q;
        case (state_q)
            CFG_IDLE: if (accept) state_d = CFG_BUSY;
            CFG_BUSY: if ((pend & ~apply) == '0) state_d = CFG_IDLE;
            default:  state_d = CFG_IDLE;
        endcase
    end

    assign cfg.cfg_ready = (state_q == CFG_IDLE);
`endif

endmodule

// File: tb/tb_led_toggle_bank.sv
// Directed bench for led_toggle_bank in the default deferred-apply build.
module tb_led_toggle_bank;

    localparam int CH = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [CH-1:0] led;
    logic [CH-1:0] tick;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    led_toggle_bank_if #(.CHANNELS(CH), .DIV_W(DW)) ifc ();

    led_toggle_bank #(.CHANNELS(CH), .DIV_W(DW)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .cfg  (ifc),
        .led  (led),
        .tick (tick)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [CH*DW-1:0] d, input logic [CH-1:0] inv);
        int n;
        n = 0;
        ifc.cfg_div   = d;
        ifc.cfg_inv   = inv;
        ifc.cfg_valid = 1'b1;
        while (!ifc.cfg_ready && n < 1000) begin
            step(1);
            n++;
        end
        check("cfg_ready_wait", {31'd0, ifc.cfg_ready}, 32'd1);
        @(posedge clk);
        #1;
        ifc.cfg_valid = 1'b0;
    endtask

    logic [CH-1:0] exp_led  [0:5];
    logic [CH-1:0] exp_tick [0:5];

    initial begin
        int  n;
        logic early;

        rst           = 1'b1;
        en            = 1'b0;
        ifc.cfg_valid = 1'b0;
        ifc.cfg_div   = '0;
        ifc.cfg_inv   = '0;
        step(2);
        check("rst_led",   {28'd0, led},  32'h0);
        check("rst_tick",  {28'd0, tick}, 32'h0);
        check("rst_ready", {31'd0, ifc.cfg_ready}, 32'd1);
        rst = 1'b0;
        en  = 1'b1;

        // ch0..ch3 divide by 1,2,3,0
        cfg_write({8'd0, 8'd3, 8'd2, 8'd1}, 4'b0000);
        check("accept_ready_low", {31'd0, ifc.cfg_ready}, 32'd0);
        check("accept_led", {28'd0, led}, 32'h0);
        step(1);
        check("apply_ready_high", {31'd0, ifc.cfg_ready}, 32'd1);
        check("apply_led", {28'd0, led}, 32'h0);

        exp_led  = '{4'b0001, 4'b0010, 4'b0111, 4'b0100, 4'b0101, 4'b0010};
        exp_tick = '{4'b0001, 4'b0011, 4'b0101, 4'b0011, 4'b0001, 4'b0111};
        for (int i = 0; i < 6; i++) begin
            step(1);
            check($sformatf("run_led_%0d", i),  {28'd0, led},  {28'd0, exp_led[i]});
            check($sformatf("run_tick_%0d", i), {28'd0, tick}, {28'd0, exp_tick[i]});
        end

        // Freeze for 10 cycles, then resume from the held counts
        en = 1'b0;
        step(1);
        check("freeze_led_first",  {28'd0, led},  32'h2);
        check("freeze_tick_first", {28'd0, tick}, 32'h0);
        step(9);
        check("freeze_led_last",  {28'd0, led},  32'h2);
        check("freeze_tick_last", {28'd0, tick}, 32'h0);
        en = 1'b1;
        step(1);
        check("resume_led_0",  {28'd0, led},  32'h3);
        check("resume_tick_0", {28'd0, tick}, 32'h1);
        step(1);
        check("resume_led_1",  {28'd0, led},  32'h0);
        check("resume_tick_1", {28'd0, tick}, 32'h3);
        step(1);
        check("resume_led_2",  {28'd0, led},  32'h5);
        check("resume_tick_2", {28'd0, tick}, 32'h5);

        // ch0 div=4 inverted, then same div non-inverted
        cfg_write({8'd0, 8'd3, 8'd2, 8'd4}, 4'b0001);
        check("inv_pre_apply", {31'd0, led[0]}, 32'd0);
        step(1);
        check("inv_apply_edge", {31'd0, led[0]}, 32'd0);
        step(3);
        check("inv_hold", {31'd0, led[0]}, 32'd0);
        step(1);
        check("inv_toggle", {31'd0, led[0]}, 32'd1);
        cfg_write({8'd0, 8'd3, 8'd2, 8'd4}, 4'b0000);
        check("uninv_pending", {31'd0, led[0]}, 32'd1);
        step(2);
        check("uninv_ready_low", {31'd0, ifc.cfg_ready}, 32'd0);
        step(1);
        check("uninv_apply_led", {31'd0, led[0]}, 32'd1);
        check("uninv_ready_high", {31'd0, ifc.cfg_ready}, 32'd1);
        step(4);
        check("uninv_true_path", {31'd0, led[0]}, 32'd0);

        // ch1 div=200, then at cnt=50 offer div=3
        cfg_write({8'd0, 8'd3, 8'd200, 8'd4}, 4'b0000);
        step(1);
        n = 0;
        while (!tick[1] && n < 20) begin
            step(1);
            n++;
        end
        check("long_apply_tick", {31'd0, tick[1]}, 32'd1);
        step(50);
        cfg_write({8'd0, 8'd3, 8'd3, 8'd4}, 4'b0000);
        check("long_ready_low", {31'd0, ifc.cfg_ready}, 32'd0);
        n     = 0;
        early = 1'b0;
        while (!ifc.cfg_ready && n < 400) begin
            if (tick[1]) early = 1'b1;
            step(1);
            n++;
        end
        check("long_ready_low_cycles", n, 32'd149);
        check("long_no_early_tick", {31'd0, early}, 32'd0);
        check("long_period_end_tick", {31'd0, tick[1]}, 32'd1);
        step(1);
        check("short_tick_gap", {31'd0, tick[1]}, 32'd0);
        step(2);
        check("short_tick_1", {31'd0, tick[1]}, 32'd1);
        step(3);
        check("short_tick_2", {31'd0, tick[1]}, 32'd1);

        // Reset while config pending discards it
        cfg_write({8'd0, 8'd0, 8'd9, 8'd9}, 4'b1111);
        check("pend_ready_low", {31'd0, ifc.cfg_ready}, 32'd0);
        rst = 1'b1;
        step(1);
        check("midrst_led",   {28'd0, led},  32'h0);
        check("midrst_tick",  {28'd0, tick}, 32'h0);
        check("midrst_ready", {31'd0, ifc.cfg_ready}, 32'd1);
        rst = 1'b0;
        step(6);
        check("post_rst_led",   {28'd0, led},  32'h0);
        check("post_rst_tick",  {28'd0, tick}, 32'h0);
        check("post_rst_ready", {31'd0, ifc.cfg_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
